// File: rtl/adc_conv_arbiter.sv
// rtl/adc_conv_arbiter.sv - round-robin arbiter sharing one ADC between three requesters
module adc_conv_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  req_ch0,
  input  logic [2:0]  req_ch1,
  input  logic [2:0]  req_ch2,
  output logic [2:0]  grant,
  output logic        conv_start,
  output logic [2:0]  conv_ch,
  input  logic        conv_busy,
  input  logic        conv_done,
  input  logic [11:0] conv_data,
  output logic [2:0]  rsp_valid,
  output logic [11:0] rsp_data,
  output logic [2:0]  rsp_ch,
  output logic        rsp_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [1:0]  owner, owner_nx, last_owner, last_owner_nx;
  logic [7:0]  timer, timer_nx;
  logic [2:0]  grant_nx, conv_ch_nx, rsp_valid_nx, rsp_ch_nx;
  logic        conv_start_nx, rsp_err_nx;
  logic [11:0] rsp_data_nx;
  logic [7:0]  err_count_nx;

  logic [1:0]  rr_base, rr_off, rr_pick;
  logic [5:0]  rr_dbl;
  logic [2:0]  rr_win, rr_sum;
  logic [2:0]  pick_ch;

  // Rotate the request vector so bit 0 is the highest-priority requester.
  always_comb begin
    rr_base = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
    rr_dbl  = {req, req} >> rr_base;
    rr_win  = rr_dbl[2:0];
    if (rr_win[0])      rr_off = 2'd0;
    else if (rr_win[1]) rr_off = 2'd1;
    else                rr_off = 2'd2;
    rr_sum  = {1'b0, rr_base} + {1'b0, rr_off};
    rr_pick = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
    case (rr_pick)
      2'd0:    pick_ch = req_ch0;
      2'd1:    pick_ch = req_ch1;
      default: pick_ch = req_ch2;
    endcase
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    timer_nx      = timer;
    grant_nx      = 3'b000;
    conv_start_nx = 1'b0;
    conv_ch_nx    = conv_ch;
    rsp_valid_nx  = 3'b000;
    rsp_data_nx   = rsp_data;
    rsp_ch_nx     = rsp_ch;
    rsp_err_nx    = rsp_err;
    err_count_nx  = err_count;
    case (state)
      IDLE: if (|req) begin
        owner_nx   = rr_pick;
        grant_nx   = 3'b001 << rr_pick;
        conv_ch_nx = pick_ch;
        state_nx   = START;
      end
      START: if (!conv_busy) begin
        conv_start_nx = 1'b1;
        timer_nx      = 8'd0;
        state_nx      = WAIT;
      end
      WAIT: begin
        // timer counts completed WAIT cycles; abort ends the TIMEOUT-th one
        if (conv_done) begin
          rsp_valid_nx = 3'b001 << owner;
          rsp_data_nx  = conv_data;
          rsp_ch_nx    = conv_ch;
          rsp_err_nx   = 1'b0;
          state_nx     = RESP;
        end else if (timer == TIMEOUT - 8'd1) begin
          rsp_valid_nx = 3'b001 << owner;
          rsp_data_nx  = 12'd0;
          rsp_ch_nx    = conv_ch;
          rsp_err_nx   = 1'b1;
          err_count_nx = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
          state_nx     = RESP;
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      RESP: begin
        last_owner_nx = owner;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      timer      <= 8'd0;
      grant      <= 3'b000;
      conv_start <= 1'b0;
      conv_ch    <= 3'd0;
      rsp_valid  <= 3'b000;
      rsp_data   <= 12'd0;
      rsp_ch     <= 3'd0;
      rsp_err    <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      timer      <= timer_nx;
      grant      <= grant_nx;
      conv_start <= conv_start_nx;
      conv_ch    <= conv_ch_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_data   <= rsp_data_nx;
      rsp_ch     <= rsp_ch_nx;
      rsp_err    <= rsp_err_nx;
      err_count  <= err_count_nx;
    end
  end

endmodule
